// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, I-type opcode offset, instruction field positions and a decode helper.
// Used by operand_issue and by the ALU downstream of it.
package alu_pkg;

  localparam int DATA_W = 16;
  localparam int NREG   = 8;
  localparam int ADDR_W = 3;
  localparam int INST_W = 16;

  localparam logic [3:0] OP_ADD    = 4'b0000;
  localparam logic [3:0] OP_SUB    = 4'b0001;
  localparam logic [3:0] OP_SLL    = 4'b0010;
  localparam logic [3:0] OP_AND    = 4'b0011;
  localparam logic [3:0] ITYPE_OFS = 4'd4;

  localparam int OP_LSB = 12;
  localparam int RD_LSB = 9;
  localparam int RS_LSB = 6;
  localparam int RT_LSB = 3;
  localparam int IMM_W  = 6;

  typedef enum logic [1:0] {
    CLS_R,
    CLS_I,
    CLS_ILL
  } inst_cls_e;

  typedef struct packed {
    inst_cls_e          cls;
    logic [3:0]         alu_op;
    logic [ADDR_W-1:0]  rd;
    logic [ADDR_W-1:0]  rs;
    logic [ADDR_W-1:0]  rt;
    logic [DATA_W-1:0]  imm;
  } dec_t;

  function automatic dec_t decode(input logic [INST_W-1:0] inst);
    dec_t       d;
    logic [3:0] op;
    op       = inst[OP_LSB +: 4];
    d.rd     = inst[RD_LSB +: ADDR_W];
    d.rs     = inst[RS_LSB +: ADDR_W];
    d.rt     = inst[RT_LSB +: ADDR_W];
    d.imm    = {{(DATA_W-IMM_W){inst[IMM_W-1]}}, inst[IMM_W-1:0]};
    d.alu_op = op;
    if (op[3]) begin
      d.cls = CLS_ILL;
    end else if (op[2]) begin
      d.cls    = CLS_I;
      d.alu_op = op - ITYPE_OFS;
    end else begin
      d.cls = CLS_R;
    end
    return d;
  endfunction

endpackage

// File: rtl/reg_file.sv
// reg_file: NREG x DATA_W, two combinational read ports, one write port, r0 hardwired to zero.
// Reads are same-cycle; with WB_BYPASS_EN a same-cycle write is forwarded to the read data.
module reg_file
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ra_addr,
  input  logic [ADDR_W-1:0] rb_addr,
  output logic [DATA_W-1:0] ra_data,
  output logic [DATA_W-1:0] rb_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  logic [DATA_W-1:0] mem_q [NREG];
  logic [DATA_W-1:0] mem_d [NREG];

  always_comb begin
    for (int i = 0; i < NREG; i++) mem_d[i] = mem_q[i];
    if (wr_en) mem_d[wr_addr] = wr_data;
    mem_d[0] = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) mem_q[i] <= mem_d[i];
    end
  end

  function automatic logic [DATA_W-1:0] rd_port(input logic [ADDR_W-1:0] addr);
`ifdef WB_BYPASS_EN
    if (wr_en && (wr_addr == addr) && (addr != '0)) return wr_data;
`endif
    return mem_q[addr];
  endfunction

  assign ra_data = rd_port(ra_addr);
  assign rb_data = rd_port(rb_addr);

endmodule

// File: rtl/operand_issue.sv
// operand_issue: decode, register read and scoreboard in front of the ALU; 1-cycle accept-to-issue latency.
// Stalls fetch on RAW/WAW hazards, never back-pressured by the ALU; WB_BYPASS_EN adds writeback forwarding.
module operand_issue
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inst_valid,
  output logic              inst_ready,
  input  logic [INST_W-1:0] inst,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_op,
  output logic              issue_valid,
  output logic [ADDR_W-1:0] issue_rd,
  output logic              illegal
);

  dec_t              dec;
  logic [DATA_W-1:0] ra_data;
  logic [DATA_W-1:0] rb_data;
  logic [NREG-1:0]   pending_q, pending_d;
  logic [NREG-1:0]   pend_eff;
  logic [NREG-1:0]   wb_onehot;
  logic              hazard;
  logic              accept;
  logic              issue;

  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic [3:0]        alu_op_q, alu_op_d;
  logic [ADDR_W-1:0] issue_rd_q, issue_rd_d;
  logic              issue_valid_q, issue_valid_d;
  logic              illegal_q, illegal_d;

  assign dec = decode(inst);

  reg_file u_reg_file (
    .clk     (clk),
    .rst_n   (rst_n),
    .ra_addr (dec.rs),
    .rb_addr (dec.rt),
    .ra_data (ra_data),
    .rb_data (rb_data),
    .wr_en   (wb_en),
    .wr_addr (wb_addr),
    .wr_data (wb_data)
  );

  always_comb begin
    wb_onehot = '0;
    if (wb_en) wb_onehot[wb_addr] = 1'b1;
  end

  // A register being written back this cycle is no longer outstanding only when forwarding exists.
`ifdef WB_BYPASS_EN
  assign pend_eff = pending_q & ~wb_onehot;
`else
  assign pend_eff = pending_q;
`endif

  assign hazard     = (dec.cls != CLS_ILL) &&
                      (pend_eff[dec.rs] || ((dec.cls == CLS_R) && pend_eff[dec.rt]) || pend_eff[dec.rd]);
  assign inst_ready = !(inst_valid && hazard);
  assign accept     = inst_valid && inst_ready;
  assign issue      = accept && (dec.cls != CLS_ILL);

  always_comb begin
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    alu_op_d      = alu_op_q;
    issue_rd_d    = issue_rd_q;
    issue_valid_d = issue;
    illegal_d     = accept && (dec.cls == CLS_ILL);
    if (issue) begin
      alu_a_d    = ra_data;
      alu_b_d    = (dec.cls == CLS_R) ? rb_data : dec.imm;
      alu_op_d   = dec.alu_op;
      issue_rd_d = dec.rd;
    end
  end

  // Clear before set so a same-cycle set of the same register wins.
  always_comb begin
    pending_d = pending_q & ~wb_onehot;
    if (issue) pending_d[dec.rd] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q     <= '0;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_op_q      <= '0;
      issue_rd_q    <= '0;
      issue_valid_q <= 1'b0;
      illegal_q     <= 1'b0;
    end else begin
      pending_q     <= pending_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      alu_op_q      <= alu_op_d;
      issue_rd_q    <= issue_rd_d;
      issue_valid_q <= issue_valid_d;
      illegal_q     <= illegal_d;
    end
  end

  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_op      = alu_op_q;
  assign issue_rd    = issue_rd_q;
  assign issue_valid = issue_valid_q;
  assign illegal     = illegal_q;

endmodule

// File: tb/tb_operand_issue.sv
// Bench for operand_issue: directed scenarios plus random traffic against an architectural model,
// with expected issues queued by the driver and checked by an independent monitor.
`timescale 1ns/1ps
module tb_operand_issue;
  import alu_pkg::*;

`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        inst_valid = 1'b0;
  logic        inst_ready;
  logic [15:0] inst = '0;
  logic        wb_en = 1'b0;
  logic [2:0]  wb_addr = '0;
  logic [15:0] wb_data = '0;
  logic [15:0] alu_a, alu_b;
  logic [3:0]  alu_op;
  logic        issue_valid;
  logic [2:0]  issue_rd;
  logic        illegal;

  always #5 clk = ~clk;

  operand_issue dut (
    .clk(clk), .rst_n(rst_n), .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .alu_a(alu_a), .alu_b(alu_b),
    .alu_op(alu_op), .issue_valid(issue_valid), .issue_rd(issue_rd), .illegal(illegal)
  );

  typedef struct {
    bit          ill;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  op;
    logic [2:0]  rd;
  } exp_t;

  exp_t        expq[$];
  logic [15:0] m_reg [8];
  bit          m_pend [8];
  logic [15:0] last_a = '0, last_b = '0;
  logic [3:0]  last_op = '0;
  logic [2:0]  last_rd = '0;
  int          n_cmp = 0, n_bad = 0;
  bit          done = 1'b0;
  bit          acc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit forwarded(input logic [2:0] r, input bit we, input logic [2:0] wa);
    return BYP && we && (wa == r) && (r != 0);
  endfunction

  function automatic bit busy(input logic [2:0] r, input bit we, input logic [2:0] wa);
    return (r != 0) && m_pend[r] && !forwarded(r, we, wa);
  endfunction

  function automatic logic [15:0] reg_val(input logic [2:0] r, input bit we, input logic [2:0] wa,
                                          input logic [15:0] wd);
    if (r == 0) return 16'h0;
    if (forwarded(r, we, wa)) return wd;
    return m_reg[r];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 8; i++) begin
      m_reg[i]  = '0;
      m_pend[i] = 1'b0;
    end
    expq.delete();
    last_a = '0; last_b = '0; last_op = '0; last_rd = '0;
  endtask

  // One clock of stimulus: drive at negedge, check ready, queue the expected issue at posedge.
  task automatic step(input bit v, input logic [15:0] ins, input bit we, input logic [2:0] wa,
                      input logic [15:0] wd, output bit accepted);
    logic [3:0] op;
    logic [2:0] rd, rs, rt;
    int         imm;
    bit         legal, rtype, hz;
    exp_t       e;
    @(negedge clk);
    inst_valid = v; inst = ins; wb_en = we; wb_addr = wa; wb_data = wd;
    op = ins[15:12]; rd = ins[11:9]; rs = ins[8:6]; rt = ins[5:3];
    imm = int'(ins[5:0]);
    if (imm > 31) imm = imm - 64;
    legal = (op < 8);
    rtype = (op < 4);
    hz = legal && (busy(rs, we, wa) || (rtype && busy(rt, we, wa)) || busy(rd, we, wa));
    #1;
    check("inst_ready", 32'(inst_ready), 32'(!(v && hz)));
    accepted = v && !hz;
    e.ill = !legal;
    e.a   = reg_val(rs, we, wa, wd);
    e.b   = rtype ? reg_val(rt, we, wa, wd) : 16'(imm);
    e.op  = rtype ? op : 4'(int'(op) - 4);
    e.rd  = rd;
    @(posedge clk);
    if (accepted) expq.push_back(e);
    if (we && wa != 0) begin
      m_reg[wa]  = wd;
      m_pend[wa] = 1'b0;
    end
    if (accepted && legal && rd != 0) m_pend[rd] = 1'b1;
  endtask

  task automatic check_issue(input string name, input logic [15:0] a, input logic [15:0] b,
                             input logic [3:0] op, input logic [2:0] rd);
    #1;
    check({name, "_vld"}, 32'(issue_valid), 32'h1);
    check({name, "_a"}, 32'(alu_a), 32'(a));
    check({name, "_b"}, 32'(alu_b), 32'(b));
    check({name, "_op"}, 32'(alu_op), 32'(op));
    check({name, "_rd"}, 32'(issue_rd), 32'(rd));
  endtask

  task automatic drain();
    bit a;
    for (int r = 1; r < 8; r++)
      if (m_pend[r]) step(1'b0, 16'h0, 1'b1, 3'(r), 16'($urandom), a);
    step(1'b0, 16'h0, 1'b0, 3'd0, 16'h0, a);
  endtask

  task automatic check_zero_outputs(input string name);
    check({name, "_vld"}, 32'(issue_valid), 32'h0);
    check({name, "_ill"}, 32'(illegal), 32'h0);
    check({name, "_a"}, 32'(alu_a), 32'h0);
    check({name, "_b"}, 32'(alu_b), 32'h0);
    check({name, "_op"}, 32'(alu_op), 32'h0);
    check({name, "_rd"}, 32'(issue_rd), 32'h0);
    check({name, "_rdy"}, 32'(inst_ready), 32'h1);
  endtask

  // Monitor: one expected entry per DUT output pulse; otherwise outputs must be idle and held.
  initial begin
    exp_t e;
    while (!done) begin
      @(posedge clk);
      #1;
      if (!rst_n) continue;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        if (e.ill) begin
          check("mon_illegal", 32'(illegal), 32'h1);
          check("mon_ill_noissue", 32'(issue_valid), 32'h0);
          check("mon_ill_hold_a", 32'(alu_a), 32'(last_a));
        end else begin
          check("mon_issue_vld", 32'(issue_valid), 32'h1);
          check("mon_issue_ill", 32'(illegal), 32'h0);
          check("mon_a", 32'(alu_a), 32'(e.a));
          check("mon_b", 32'(alu_b), 32'(e.b));
          check("mon_op", 32'(alu_op), 32'(e.op));
          check("mon_rd", 32'(issue_rd), 32'(e.rd));
          last_a = e.a; last_b = e.b; last_op = e.op; last_rd = e.rd;
        end
      end else begin
        check("mon_idle", 32'({issue_valid, illegal}), 32'h0);
        check("mon_hold", 32'({alu_a, alu_b, alu_op, 1'b0, issue_rd}),
              32'({last_a, last_b, last_op, 1'b0, last_rd}));
      end
    end
  end

  initial begin
    logic [15:0] ins;
    logic [2:0]  wa;
    bit          we;
    int          np;
    logic [2:0]  plist[$];

    model_clear();
    #12;
    check_zero_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Writebacks then ADD r3,r1,r2
    step(1'b0, 16'h0, 1'b1, 3'd1, 16'd5, acc);
    step(1'b0, 16'h0, 1'b1, 3'd2, 16'd3, acc);
    step(1'b1, 16'h0650, 1'b0, 3'd0, 16'h0, acc);
    check_issue("add", 16'd5, 16'd3, OP_ADD, 3'd3);
    // ADDI r1,r1,-1
    step(1'b1, 16'h427F, 1'b0, 3'd0, 16'h0, acc);
    check_issue("addi", 16'd5, 16'hFFFF, OP_ADD, 3'd1);
    step(1'b0, 16'h0, 1'b1, 3'd1, 16'd5, acc);
    step(1'b0, 16'h0, 1'b1, 3'd3, 16'd9, acc);

    // RAW: SUB r4,r3,r1 waits for the r3 writeback
    step(1'b1, 16'h0650, 1'b0, 3'd0, 16'h0, acc);
    step(1'b1, 16'h18C8, 1'b0, 3'd0, 16'h0, acc);
    check("raw_stall1", 32'(acc), 32'h0);
    step(1'b1, 16'h18C8, 1'b0, 3'd0, 16'h0, acc);
    check("raw_stall2", 32'(acc), 32'h0);
    step(1'b1, 16'h18C8, 1'b1, 3'd3, 16'h0077, acc);
    if (!acc) step(1'b1, 16'h18C8, 1'b0, 3'd0, 16'h0, acc);
    check_issue("sub", 16'h0077, 16'd5, OP_SUB, 3'd4);
    drain();

    // Illegal op consumed without issue or scoreboard change
    step(1'b1, 16'h9000, 1'b0, 3'd0, 16'h0, acc);
    #1;
    check("ill_pulse", 32'(illegal), 32'h1);
    check("ill_noissue", 32'(issue_valid), 32'h0);
    step(1'b1, 16'h0650, 1'b0, 3'd0, 16'h0, acc);
    check("after_ill_accept", 32'(acc), 32'h1);
    drain();

    // r0: writes ignored, never pending
    step(1'b0, 16'h0, 1'b1, 3'd0, 16'h1234, acc);
    step(1'b1, 16'h0000, 1'b0, 3'd0, 16'h0, acc);
    check_issue("r0_add", 16'h0, 16'h0, OP_ADD, 3'd0);
    step(1'b1, 16'h0050, 1'b0, 3'd0, 16'h0, acc);
    check_issue("r0_dst", 16'd5, 16'd3, OP_ADD, 3'd0);
    step(1'b1, 16'h0A00, 1'b0, 3'd0, 16'h0, acc);
    check_issue("r0_src", 16'h0, 16'h0, OP_ADD, 3'd5);
    drain();

    // Reset in the middle of an issue
    step(1'b1, 16'h0650, 1'b0, 3'd0, 16'h0, acc);
    #2;
    rst_n = 1'b0;
    inst_valid = 1'b1;
    inst = 16'h18C8;
    #1;
    check_zero_outputs("midreset");
    model_clear();
    @(negedge clk);
    inst_valid = 1'b0;
    rst_n = 1'b1;

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      ins = 16'($urandom);
      ins[15:12] = 4'($urandom_range(0, 9));
      plist.delete();
      for (int r = 1; r < 8; r++) if (m_pend[r]) plist.push_back(3'(r));
      np = plist.size();
      we = 1'b0;
      wa = '0;
      if (np > 0 && $urandom_range(0, 2) == 0) begin
        we = 1'b1;
        wa = plist[$urandom_range(0, np - 1)];
      end else if ($urandom_range(0, 9) == 0) begin
        we = 1'b1;
        wa = 3'($urandom_range(0, 7));
      end
      step($urandom_range(0, 3) != 0, ins, we, wa, 16'($urandom), acc);
    end
    drain();
    step(1'b0, 16'h0, 1'b0, 3'd0, 16'h0, acc);

    done = 1'b1;
    @(posedge clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
